int8_dot_accum: RTL and testbench

- Downstream consumer of the signed INT8 Booth multiplier. Accumulates a stream of signed 16-bit products into a signed ACC_W-bit dot-product result.
- Vector boundaries are marked by in_last. The finished sum is presented on a valid/ready output register.
- Sits between the multiplier array and the tensor-core result writeback.

---
 rtl/int8_dot_accum.sv | 141 ++++++++++++++
 tb/tb_int8_dot_accum.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int8_dot_accum.sv
// int8_dot_accum: accumulates a stream of signed products into a signed
// dot-product sum. The vector end is marked by in_last, and the finished sum
// is held in a valid/ready result register.
// Optional feature: define INT8_DOT_ACCUM_SAT_EN to saturate the accumulator
// on signed overflow. Without it the accumulator wraps in two's complement.
// In both builds out_ovf reports that an overflow occurred in the vector.
//
// Handshake contract: a product is taken on a rising edge when
// in_valid & in_ready, and a result is taken when out_valid & out_ready.
// in_ready = ~out_valid | out_ready, so a result leaving in the same cycle
// frees the register for the next one. clr discards any product presented
// with it. The control state is out_valid alone: it is EMPTY when 0 and
// FULL when 1.
module int8_dot_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef INT8_DOT_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_fire;
  logic             out_fire;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum_raw;
  logic [ACC_W-1:0] sum_next;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = ~out_valid_q | out_ready;
  assign in_fire  = in_valid & in_ready & ~clr;
  assign out_fire = out_valid_q & out_ready;

  // Add the sign-extended product and detect signed overflow of that add.
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    sum_raw  = acc_q + prod_ext;
    add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef INT8_DOT_ACCUM_SAT_EN
    // An overflowing add can only leave the range on the side of the
    // operands' common sign, so clamp toward that limit.
    if (add_ovf) begin
      sum_next = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_next = sum_raw;
    end
`else
    sum_next = sum_raw;
`endif
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  end

  // Next state: clr wins over an accept; a last accept loads the result and restarts the vector.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (in_fire) begin
      if (in_last) begin
        out_sum_d   = sum_next;
        out_count_d = cnt_inc;
        out_ovf_d   = sticky_q | add_ovf;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        sticky_d    = 1'b0;
      end else begin
        acc_d    = sum_next;
        cnt_d    = cnt_inc;
        sticky_d = sticky_q | add_ovf;
      end
    end
  end

  // State registers; reset drops everything, including a pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_int8_dot_accum.sv
// Bench for int8_dot_accum. Instance dut_a uses the default widths
// (ACC_W=32, CNT_W=16), and instance dut_b uses ACC_W=17, CNT_W=4 so that
// overflow and count saturation are easy to reach. Both instances share the
// same inputs. A reference model computes each vector's result from the
// list of accepted products using plain integer arithmetic.
module tb_int8_dot_accum;

  localparam int RW = 49;  // {sum[31:0], count[15:0], ovf}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] in_prod = '0;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [31:0] out_sum_a;
  logic [15:0] out_count_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [16:0] out_sum_b;
  logic [3:0]  out_count_b;

  int n_checks = 0;
  int n_fail = 0;
  int rule_err = 0;
  int stall_cnt = 0;
  bit rand_mode = 1'b0;

  logic signed [15:0] cur_q[$];
  logic [RW-1:0] exp_a_q[$];
  logic [RW-1:0] exp_b_q[$];
  logic [RW-1:0] got_a_q[$];
  logic [RW-1:0] got_b_q[$];

  int8_dot_accum dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
  );

  int8_dot_accum #(.PROD_W(16), .ACC_W(17), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  // clock
  always #5 clk = ~clk;

  // Reference: result for the current product list at accumulator width w
  // and counter width cw.
  function automatic logic [RW-1:0] model_res(input int w, input int cw);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -(longint'(1) <<< (w - 1));
    longint cmax = (longint'(1) <<< cw) - 1;
    longint acc = 0;
    longint s;
    longint cnt;
    bit ovf = 1'b0;
    foreach (cur_q[i]) begin
      s = acc + longint'(cur_q[i]);
      if (s > mx || s < mn) begin
        ovf = 1'b1;
`ifdef INT8_DOT_ACCUM_SAT_EN
        acc = (s > mx) ? mx : mn;
`else
        acc = (s > mx) ? s - (longint'(1) <<< w) : s + (longint'(1) <<< w);
`endif
      end else begin
        acc = s;
      end
    end
    cnt = (longint'(cur_q.size()) > cmax) ? cmax : longint'(cur_q.size());
    return {acc[31:0], cnt[15:0], ovf};
  endfunction

  // Monitor: sample handshakes mid-cycle, feed the model, and collect results.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_q.delete();
    end else begin
      if (in_ready_a !== (~out_valid_a | out_ready) || in_ready_b !== in_ready_a ||
          out_valid_b !== out_valid_a)
        rule_err++;
      if (out_valid_a && out_ready) begin
        got_a_q.push_back({out_sum_a, out_count_a, out_ovf_a});
        got_b_q.push_back({{15{out_sum_b[16]}}, out_sum_b, 12'd0, out_count_b, out_ovf_b});
      end
      if (clr) begin
        cur_q.delete();
      end else if (in_valid && in_ready_a) begin
        cur_q.push_back(in_prod);
        if (in_last) begin
          exp_a_q.push_back(model_res(32, 16));
          exp_b_q.push_back(model_res(17, 4));
          cur_q.delete();
        end
      end
    end
  end

  // Drive one product, optionally with clr, and hold it until it is taken.
  task automatic send(input logic [15:0] p, input logic l, input logic c);
    int n = 0;
    in_valid = 1'b1; in_prod = p; in_last = l; clr = c;
    @(negedge clk);
    while (in_ready_a !== 1'b1 && c == 1'b0 && n < 64) begin
      @(posedge clk); #1;
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      stall_cnt++;
    end
    if (n >= 64) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout in_ready=%b expected 1", in_ready_a);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string nm);
    int n = 0;
    out_ready = 1'b1;
    while (out_valid_a === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (out_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain out_valid=%b expected 0", nm, out_valid_a);
    end
  endtask

  task automatic flush();
    cur_q.delete(); exp_a_q.delete(); exp_b_q.delete(); got_a_q.delete(); got_b_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid_a, out_sum_a, out_count_a, out_ovf_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a got v=%b sum=%0d cnt=%0d ovf=%b expected all 0",
               out_valid_a, out_sum_a, out_count_a, out_ovf_a);
    end
    n_checks++;
    if ({out_valid_b, out_sum_b, out_count_b, out_ovf_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b got v=%b sum=%0d cnt=%0d ovf=%b expected all 0",
               out_valid_b, out_sum_b, out_count_b, out_ovf_b);
    end
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    flush(); out_ready = 1'b1; stall_cnt = 0;
    send(16'sd100, 1'b0, 1'b0);
    send(-16'sd3, 1'b0, 1'b0);
    n_checks++;
    if (out_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_valid got %b expected 0", out_valid_a);
    end
    send(16'sd7, 1'b1, 1'b0);
    n_checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 32'd104 || out_count_a !== 16'd3 || out_ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result got v=%b sum=%0d cnt=%0d ovf=%b expected v=1 sum=104 cnt=3 ovf=0",
               out_valid_a, $signed(out_sum_a), out_count_a, out_ovf_a);
    end
    n_checks++;
    if (out_sum_b !== 17'd104 || out_count_b !== 4'd3) begin
      n_fail++; $display("FAIL basic_result_b got sum=%0d cnt=%0d expected 104/3", $signed(out_sum_b), out_count_b);
    end
    n_checks++;
    if (stall_cnt != 0) begin
      n_fail++; $display("FAIL basic_in_ready stalls=%0d expected 0", stall_cnt);
    end
    drain("basic");
  endtask

  task automatic test_backpressure();
    flush(); out_ready = 1'b0;
    send(16'sd11, 1'b1, 1'b0);
    in_valid = 1'b1; in_prod = 16'sd5; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_sum_a !== 32'd11) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b sum=%0d expected rdy=0 v=1 sum=11",
                 i, in_ready_a, out_valid_a, $signed(out_sum_a));
      end
      @(posedge clk); #1;
    end
    in_prod = 16'sh8000; in_last = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL bp_release in_ready got %b expected 1", in_ready_a);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 32'hFFFF8000 || out_count_a !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_new_result got v=%b sum=%0d cnt=%0d expected v=1 sum=-32768 cnt=1",
               out_valid_a, $signed(out_sum_a), out_count_a);
    end
    n_checks++;
    if (got_a_q.size() != 1 || got_a_q[0] !== {32'd11, 16'd1, 1'b0}) begin
      n_fail++; $display("FAIL bp_old_result taken=%0d expected one result sum=11 cnt=1", got_a_q.size());
    end
    drain("bp");
  endtask

  task automatic test_back_to_back();
    longint t0;
    logic [RW-1:0] e;
    logic [RW-1:0] g;
    flush(); out_ready = 1'b1;
    t0 = longint'($time);
    for (int i = 0; i < 20; i++) begin
      send(16'($urandom), 1'b0, 1'b0);
      send(16'($urandom), 1'b1, 1'b0);
    end
    n_checks++;
    if (longint'($time) - t0 != 400) begin
      n_fail++; $display("FAIL b2b_throughput took %0d time units expected 400", longint'($time) - t0);
    end
    drain("b2b");
    n_checks++;
    if (got_a_q.size() != 20 || exp_a_q.size() != 20) begin
      n_fail++; $display("FAIL b2b_count got %0d results expected 20 (model %0d)", got_a_q.size(), exp_a_q.size());
    end
    while (exp_a_q.size() > 0 && got_a_q.size() > 0) begin
      e = exp_a_q.pop_front(); g = got_a_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL b2b_a got %h expected %h", g, e);
      end
    end
    while (exp_b_q.size() > 0 && got_b_q.size() > 0) begin
      e = exp_b_q.pop_front(); g = got_b_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL b2b_b got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_clr();
    flush(); out_ready = 1'b0;
    send(16'sd3, 1'b1, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_prod = 16'sd9;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 32'd3 || out_count_a !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_pending got v=%b sum=%0d cnt=%0d expected v=1 sum=3 cnt=1",
               out_valid_a, $signed(out_sum_a), out_count_a);
    end
    out_ready = 1'b1;
    send(16'sd5, 1'b0, 1'b0);
    send(16'sd6, 1'b0, 1'b0);
    send(16'sd9, 1'b0, 1'b1);
    send(16'sd2, 1'b1, 1'b0);
    n_checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 32'd2 || out_count_a !== 16'd1 || out_ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_result got v=%b sum=%0d cnt=%0d ovf=%b expected v=1 sum=2 cnt=1 ovf=0",
               out_valid_a, $signed(out_sum_a), out_count_a, out_ovf_a);
    end
    n_checks++;
    if (out_sum_b !== 17'd2 || out_count_b !== 4'd1) begin
      n_fail++; $display("FAIL clr_result_b got sum=%0d cnt=%0d expected 2/1", $signed(out_sum_b), out_count_b);
    end
    drain("clr");
    n_checks++;
    if (got_a_q.size() != 2 || got_a_q[0] !== {32'd3, 16'd1, 1'b0}) begin
      n_fail++; $display("FAIL clr_sequence got %0d results expected 2 with first sum=3", got_a_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [16:0] exp_pos;
    logic [16:0] exp_neg;
`ifdef INT8_DOT_ACCUM_SAT_EN
    exp_pos = 17'h0FFFF;  // +65535
    exp_neg = 17'h10000;  // -65536
`else
    exp_pos = 17'h1FFFC;  // 131068 wrapped at 17 bits = -4
    exp_neg = 17'h18000;  // -163840 wrapped at 17 bits = -32768
`endif
    flush(); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(16'sd32767, 1'(i == 3), 1'b0);
    n_checks++;
    if (out_sum_b !== exp_pos || out_ovf_b !== 1'b1 || out_count_b !== 4'd4) begin
      n_fail++;
      $display("FAIL ovf_pos_b got sum=%0d ovf=%b cnt=%0d expected sum=%0d ovf=1 cnt=4",
               $signed(out_sum_b), out_ovf_b, out_count_b, $signed(exp_pos));
    end
    n_checks++;
    if (out_sum_a !== 32'd131068 || out_ovf_a !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pos_a got sum=%0d ovf=%b expected 131068/0", $signed(out_sum_a), out_ovf_a);
    end
    for (int i = 0; i < 5; i++) send(16'sh8000, 1'(i == 4), 1'b0);
    n_checks++;
    if (out_sum_b !== exp_neg || out_ovf_b !== 1'b1 || out_count_b !== 4'd5) begin
      n_fail++;
      $display("FAIL ovf_neg_b got sum=%0d ovf=%b cnt=%0d expected sum=%0d ovf=1 cnt=5",
               $signed(out_sum_b), out_ovf_b, out_count_b, $signed(exp_neg));
    end
    n_checks++;
    if (out_sum_a !== 32'hFFFD8000 || out_ovf_a !== 1'b0) begin
      n_fail++; $display("FAIL ovf_neg_a got sum=%0d ovf=%b expected -163840/0", $signed(out_sum_a), out_ovf_a);
    end
    drain("ovf");
  endtask

  task automatic test_count_sat();
    flush(); out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(16'sd1, 1'(i == 19), 1'b0);
    n_checks++;
    if (out_count_a !== 16'd20 || out_sum_a !== 32'd20) begin
      n_fail++; $display("FAIL cnt_a got cnt=%0d sum=%0d expected 20/20", out_count_a, $signed(out_sum_a));
    end
    n_checks++;
    if (out_count_b !== 4'd15 || out_sum_b !== 17'd20) begin
      n_fail++; $display("FAIL cnt_sat_b got cnt=%0d sum=%0d expected 15/20", out_count_b, $signed(out_sum_b));
    end
    drain("cnt");
  endtask

  task automatic test_random();
    int len;
    logic [RW-1:0] e;
    logic [RW-1:0] g;
    flush(); rand_mode = 1'b1; out_ready = 1'b1;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 11) == 0) send(16'($urandom), 1'b0, 1'b1);
        send(($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 200)),
             1'(k == len - 1), 1'b0);
      end
    end
    rand_mode = 1'b0;
    drain("rand");
    n_checks++;
    if (got_a_q.size() != 40 || exp_a_q.size() != 40) begin
      n_fail++; $display("FAIL rand_count got %0d results expected 40 (model %0d)", got_a_q.size(), exp_a_q.size());
    end
    while (exp_a_q.size() > 0 && got_a_q.size() > 0) begin
      e = exp_a_q.pop_front(); g = got_a_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL rand_a got %h expected %h", g, e);
      end
    end
    while (exp_b_q.size() > 0 && got_b_q.size() > 0) begin
      e = exp_b_q.pop_front(); g = got_b_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++; $display("FAIL rand_b got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_async_reset();
    flush(); out_ready = 1'b0;
    send(16'sd6, 1'b1, 1'b0);
    n_checks++;
    if (out_valid_a !== 1'b1) begin
      n_fail++; $display("FAIL arst_setup out_valid got %b expected 1", out_valid_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid_a, out_sum_a, out_count_a, out_ovf_a, out_valid_b, out_sum_b, out_count_b} !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate got v=%b sum=%0d cnt=%0d expected all 0", out_valid_a, out_sum_a, out_count_a);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    flush(); out_ready = 1'b1;
    send(16'sd9, 1'b0, 1'b0);
    send(16'sd8, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    flush();
    send(16'sd2, 1'b1, 1'b0);
    n_checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 32'd2 || out_count_a !== 16'd1 || out_sum_b !== 17'd2) begin
      n_fail++;
      $display("FAIL arst_fresh_vector got v=%b sum=%0d cnt=%0d expected v=1 sum=2 cnt=1",
               out_valid_a, $signed(out_sum_a), out_count_a);
    end
    drain("arst");
  endtask

  task automatic test_handshake_rule();
    n_checks++;
    if (rule_err != 0) begin
      n_fail++; $display("FAIL in_ready_rule violations=%0d expected 0", rule_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_clr();
    test_overflow();
    test_count_sat();
    test_random();
    test_async_reset();
    test_handshake_rule();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
